// File: rtl/bram_ifm_wide_burst_if.sv
// Port bundle for the IFM buffer: wide write port, lane read/burst request, and
// the valid/ready output stream. The master drives requests; the slave is the buffer.
interface bram_ifm_wide_burst_if #(
    parameter int WR_WIDTH   = 128,
    parameter int RD_WIDTH   = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
);
    localparam int R = WR_WIDTH / RD_WIDTH;

    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [R-1:0]          wr_lane_mask;
    logic [WR_WIDTH-1:0]   data_in;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  burst_start;
    logic [ADDR_WIDTH-1:0] burst_base;
    logic [LEN_WIDTH-1:0]  burst_len;
    // Stream handshake: a beat moves on a rising clk edge where data_valid && out_ready;
    // data_out never changes while data_valid=1 and out_ready=0.
    logic                  out_ready;
    logic [RD_WIDTH-1:0]   data_out;
    logic                  data_valid;
    logic                  burst_busy;
    logic                  burst_done;
    logic                  addr_err;
    logic [1:0]            fsm_state;

    modport master (
        output wr_en, wr_addr, wr_lane_mask, data_in,
        output rd_en, rd_addr, burst_start, burst_base, burst_len, out_ready,
        input  data_out, data_valid, burst_busy, burst_done, addr_err, fsm_state
    );

    modport slave (
        input  wr_en, wr_addr, wr_lane_mask, data_in,
        input  rd_en, rd_addr, burst_start, burst_base, burst_len, out_ready,
        output data_out, data_valid, burst_busy, burst_done, addr_err, fsm_state
    );
endinterface

// File: rtl/bram_ifm_wide_burst.sv
// IFM buffer: WR_WIDTH-bit masked writes, RD_WIDTH-bit lane reads, and a burst
// sequencer feeding a 2-entry output FIFO with valid/ready backpressure.
module bram_ifm_wide_burst #(
    parameter int WR_WIDTH   = 128,
    parameter int RD_WIDTH   = 32,
    parameter int DEPTH      = 25088,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input logic                clk,
    input logic                rst,
    bram_ifm_wide_burst_if.slave bus
);
    localparam int R      = WR_WIDTH / RD_WIDTH;
    localparam int WORD_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] WORDS     = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LANES     = ADDR_WIDTH'(DEPTH * R);
    localparam logic [ADDR_WIDTH-1:0] LAST_LANE = ADDR_WIDTH'(DEPTH * R - 1);
    localparam logic [ADDR_WIDTH-1:0] R_A       = ADDR_WIDTH'(R);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [WR_WIDTH-1:0]   mem [DEPTH];
    logic [1:0]            state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic [RD_WIDTH-1:0]   fifo_q [2];
    logic                  rd_ptr_q;
    logic                  wr_ptr_q;
    logic [1:0]            count_q;
    logic                  addr_err_q;

    logic                  rand_issue;
    logic                  burst_issue;
    logic                  push;
    logic                  pop;
    logic                  push_err;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic [ADDR_WIDTH-1:0] issue_lane;
    logic [WR_WIDTH-1:0]   issue_row;
    logic [RD_WIDTH-1:0]   push_data;

    // The memory is read combinationally and the selected lane is captured into the
    // FIFO at the issuing edge, so an accepted read is visible one cycle later and a
    // same-cycle write (committed at that edge) is not seen: read-first behaviour.
    always_comb begin
        rand_issue  = (state_q == IDLE) && !bus.burst_start && bus.rd_en && (count_q != 2'd2);
        burst_issue = (state_q == RUN) && (count_q != 2'd2);
        push        = rand_issue || burst_issue;
        pop         = (count_q != 2'd0) && bus.out_ready;
        issue_addr  = burst_issue ? addr_q : bus.rd_addr;
        issue_lane  = issue_addr % R_A;
        issue_row   = mem[WORD_W'(issue_addr / R_A)];
        in_range    = issue_addr < LANES;
        push_err    = push && !in_range;
        push_data   = in_range ? issue_row[issue_lane*RD_WIDTH +: RD_WIDTH] : '0;
    end

    always_ff @(posedge clk) begin
        if (bus.wr_en && (bus.wr_addr < WORDS)) begin
            for (int i = 0; i < R; i++) begin
                if (bus.wr_lane_mask[i])
                    mem[WORD_W'(bus.wr_addr)][i*RD_WIDTH +: RD_WIDTH] <= bus.data_in[i*RD_WIDTH +: RD_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.burst_start) begin
                        addr_q      <= bus.burst_base;
                        remaining_q <= bus.burst_len;
                        state_q     <= (bus.burst_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (burst_issue) begin
                        addr_q      <= (addr_q == LAST_LANE) ? '0 : addr_q + 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                        if (remaining_q == LEN_WIDTH'(1)) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count_q == 2'd0) state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= push_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Sticky error: out-of-range writes and any out-of-range lane issue.
    always_ff @(posedge clk) begin
        if (rst)
            addr_err_q <= 1'b0;
        else if (push_err || (bus.wr_en && (bus.wr_addr >= WORDS)))
            addr_err_q <= 1'b1;
    end

    assign bus.data_valid = (count_q != 2'd0);
    assign bus.data_out   = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : '0;
    assign bus.burst_busy = (state_q != IDLE);
    assign bus.burst_done = (state_q == DONE);
    assign bus.addr_err   = addr_err_q;
    assign bus.fsm_state  = state_q;
endmodule

// File: tb/tb_bram_ifm_wide_burst.sv
// Directed and randomized bench for bram_ifm_wide_burst: lane-array reference model,
// expected-beat queue scoreboard, and burst timing/backpressure checks.
`timescale 1ns/1ps
module tb_bram_ifm_wide_burst;
    localparam int WR_WIDTH   = 128;
    localparam int RD_WIDTH   = 32;
    localparam int DEPTH      = 64;
    localparam int ADDR_WIDTH = 32;
    localparam int LEN_WIDTH  = 16;
    localparam int R          = WR_WIDTH / RD_WIDTH;
    localparam int LANES      = DEPTH * R;
    localparam int LW         = $clog2(LANES);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_ifm_wide_burst_if #(.WR_WIDTH(WR_WIDTH), .RD_WIDTH(RD_WIDTH),
                             .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) bus ();

    bram_ifm_wide_burst #(.WR_WIDTH(WR_WIDTH), .RD_WIDTH(RD_WIDTH), .DEPTH(DEPTH),
                          .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int beats  = 0;
    int ready_mode = 0;
    logic exp_err = 1'b0;
    logic [RD_WIDTH-1:0] ref_mem [LANES];
    logic [RD_WIDTH-1:0] exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RD_WIDTH-1:0] model_lane(input int a);
        if (a < 0 || a >= LANES) return '0;
        return ref_mem[a[LW-1:0]];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Consumer: always ready, a 1-0-0 stall pattern, or random.
    initial begin
        int phase = 0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (phase % 3 == 0);
                default: bus.out_ready = ($urandom_range(0, 1) == 1);
            endcase
            phase++;
        end
    end

    // Scoreboard: every transferred beat must match the head of exp_q, and a stalled
    // beat must stay valid with unchanged data.
    initial begin
        logic held_v;
        logic [RD_WIDTH-1:0] held_d;
        held_v = 1'b0;
        held_d = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    check("stall_valid_held", bus.data_valid, 1);
                    check("stall_data_stable", bus.data_out, held_d);
                end
                if (bus.data_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) check("spurious_beat", 64'(exp_q.size()), 1);
                    else check("beat_data", bus.data_out, exp_q.pop_front());
                    beats++;
                    held_v = 1'b0;
                end else if (bus.data_valid) begin
                    held_v = 1'b1;
                    held_d = bus.data_out;
                end else begin
                    held_v = 1'b0;
                end
            end
        end
    end

    task automatic do_write(input int w, input logic [R-1:0] m, input logic [WR_WIDTH-1:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = ADDR_WIDTH'(w);
        bus.wr_lane_mask = m;
        bus.data_in = d;
        if (w < DEPTH) begin
            for (int i = 0; i < R; i++)
                if (m[i]) ref_mem[(w*R + i) % LANES] = d[i*RD_WIDTH +: RD_WIDTH];
        end else begin
            exp_err = 1'b1;
        end
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic do_read(input int a);
        logic [RD_WIDTH-1:0] e;
        e = model_lane(a);
        exp_q.push_back(e);
        if (a >= LANES) exp_err = 1'b1;
        bus.rd_en = 1'b1;
        bus.rd_addr = ADDR_WIDTH'(a);
        tick();
        bus.rd_en = 1'b0;
        check("rd_latency_valid", bus.data_valid, 1);
        check("rd_latency_data", bus.data_out, e);
        check("rd_addr_err", bus.addr_err, exp_err);
    endtask

    task automatic do_write_read(input int w, input logic [WR_WIDTH-1:0] d, input int a);
        logic [RD_WIDTH-1:0] e;
        e = model_lane(a);
        exp_q.push_back(e);
        bus.wr_en = 1'b1;
        bus.wr_addr = ADDR_WIDTH'(w);
        bus.wr_lane_mask = '1;
        bus.data_in = d;
        bus.rd_en = 1'b1;
        bus.rd_addr = ADDR_WIDTH'(a);
        for (int i = 0; i < R; i++) ref_mem[(w*R + i) % LANES] = d[i*RD_WIDTH +: RD_WIDTH];
        tick();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check("read_first_data", bus.data_out, e);
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((bus.data_valid || bus.burst_busy) && c < 60) begin
            tick();
            c++;
        end
        check("drain_in_time", bus.data_valid || bus.burst_busy, 0);
        if (c >= 60) exp_q.delete();
    endtask

    task automatic run_burst(input int base, input int len, input bit timing);
        int b0, first_v, nvalid, dones;
        bit finished;
        for (int k = 0; k < len; k++)
            exp_q.push_back(model_lane((base < LANES) ? (base + k) % LANES : base + k));
        if (base >= LANES && len > 0) exp_err = 1'b1;
        b0 = beats;
        first_v = -1;
        nvalid = 0;
        dones = 0;
        finished = 1'b0;
        bus.burst_start = 1'b1;
        bus.burst_base = ADDR_WIDTH'(base);
        bus.burst_len = LEN_WIDTH'(len);
        for (int cyc = 0; cyc < 40 + len*6 && !finished; cyc++) begin
            @(negedge clk);
            if (bus.data_valid) begin
                nvalid++;
                if (first_v < 0) first_v = cyc;
            end
            if (bus.burst_done) dones++;
            if (cyc > 0 && !bus.burst_busy) finished = 1'b1;
            tick();
            bus.burst_start = 1'b0;
        end
        check("burst_finished", finished, 1);
        check("burst_done_pulses", dones, 1);
        check("burst_beats", beats - b0, len);
        check("burst_queue_empty", 64'(exp_q.size()), 0);
        check("burst_addr_err", bus.addr_err, exp_err);
        if (timing) begin
            check("burst_first_valid_cycle", first_v, (len > 0) ? 2 : -1);
            check("burst_valid_cycles", nvalid, len);
        end
        if (!finished) exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b0, hits;
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_lane_mask = '0; bus.data_in = '0;
        bus.rd_en = 1'b0; bus.rd_addr = '0;
        bus.burst_start = 1'b0; bus.burst_base = '0; bus.burst_len = '0;
        rst = 1'b1;
        repeat (3) tick();
        check("reset_data_out", bus.data_out, 0);
        check("reset_data_valid", bus.data_valid, 0);
        check("reset_burst_busy", bus.burst_busy, 0);
        check("reset_burst_done", bus.burst_done, 0);
        check("reset_addr_err", bus.addr_err, 0);
        rst = 1'b0;
        tick();

        for (int w = 0; w < DEPTH; w++)
            do_write(w, '1, {$urandom, $urandom, $urandom, $urandom});

        // Directed lane mapping and lane masking on word 5 (lanes 20..23).
        do_write(5, 4'hF, 128'h44444444_33333333_22222222_11111111);
        for (int a = 20; a < 24; a++) do_read(a);
        wait_drain();
        do_write(5, 4'b0100, {4{32'hFFFF_FFFF}});
        for (int a = 20; a < 24; a++) do_read(a);
        wait_drain();
        check("mask_lane2_value", model_lane(22), 32'hFFFF_FFFF);

        do_write_read(7, {4{32'hA5A5_5A5A}}, 29);
        wait_drain();
        do_read(29);
        wait_drain();

        ready_mode = 0;
        run_burst(20, 8, 1'b1);
        ready_mode = 1;
        run_burst(20, 8, 1'b0);
        ready_mode = 0;
        run_burst(LANES - 2, 4, 1'b0);
        check("wrap_no_err", bus.addr_err, 0);

        do_read(LANES);
        wait_drain();
        do_read(3);
        wait_drain();
        check("addr_err_sticky", bus.addr_err, 1);

        run_burst(0, 0, 1'b1);
        run_burst(LANES + 5, 3, 1'b0);

        // Out-of-range write is dropped (no alias onto word 0) and flags an error.
        rst = 1'b1; tick(); rst = 1'b0; exp_err = 1'b0;
        check("err_cleared_by_rst", bus.addr_err, 0);
        do_write(DEPTH, '1, {4{32'hDEAD_BEEF}});
        check("wr_oor_err", bus.addr_err, 1);
        for (int a = 0; a < R; a++) do_read(a);
        wait_drain();

        // Abort a burst with reset after its third beat.
        rst = 1'b1; tick(); rst = 1'b0; exp_err = 1'b0;
        for (int k = 0; k < 8; k++) exp_q.push_back(model_lane(40 + k));
        b0 = beats;
        bus.burst_start = 1'b1; bus.burst_base = 40; bus.burst_len = 8;
        tick();
        bus.burst_start = 1'b0;
        for (int c = 0; c < 100 && (beats - b0) < 3; c++) tick();
        check("abort_after_3_beats", beats - b0, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("abort_data_out", bus.data_out, 0);
        check("abort_data_valid", bus.data_valid, 0);
        check("abort_burst_busy", bus.burst_busy, 0);
        check("abort_burst_done", bus.burst_done, 0);
        check("abort_addr_err", bus.addr_err, 0);
        hits = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.burst_done || bus.data_valid) hits++;
        end
        check("abort_no_done_no_data", hits, 0);
        do_read(45);
        wait_drain();

        // Randomized mix of writes, reads (some out of range) and bursts.
        ready_mode = 2;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 2))
                0: do_write($urandom_range(0, DEPTH - 1), R'($urandom_range(0, (1 << R) - 1)),
                            {$urandom, $urandom, $urandom, $urandom});
                1: do_read($urandom_range(0, LANES + 16));
                default: run_burst($urandom_range(0, LANES - 1), $urandom_range(1, 10), 1'b0);
            endcase
            wait_drain();
        end
        check("final_queue_empty", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bram_ifm_wide_burst.md
Name: bram_ifm_wide_burst

Overview:
IFM buffer with a wide write port and a narrow read port. It stores WR_WIDTH-bit words and serves RD_WIDTH-bit lanes selected by a lane-granular read address. It adds per-lane write masking, address range checking, and a burst read sequencer with valid/ready backpressure. It sits between the DMA/IFM loader (128-bit writes) and the PE-array feeder (32-bit reads).

Parameters:
WR_WIDTH, 128, write word width in bits; must be an integer multiple of RD_WIDTH.
RD_WIDTH, 32, read lane width in bits.
DEPTH, 25088, number of WR_WIDTH words stored (100352 lanes at the defaults).
ADDR_WIDTH, 32, width of all address ports.
LEN_WIDTH, 16, width of the burst length port.

Ports:
clk  in  1  clock; all logic is on the rising edge
rst  in  1  synchronous, active-high reset
wr_en  in  1  write strobe
wr_addr  in  ADDR_WIDTH  word address, in WR_WIDTH units
wr_lane_mask  in  R  per-lane write enable, R = WR_WIDTH/RD_WIDTH; bit i gates data_in[i*RD_WIDTH +: RD_WIDTH]
data_in  in  WR_WIDTH  write data
rd_en  in  1  single random read request; accepted only in IDLE
rd_addr  in  ADDR_WIDTH  lane address, in RD_WIDTH units
burst_start  in  1  burst request; accepted only in IDLE
burst_base  in  ADDR_WIDTH  first lane address of the burst
burst_len  in  LEN_WIDTH  number of lanes to read
out_ready  in  1  consumer ready
data_out  out  RD_WIDTH  read data
data_valid  out  1  data_out is valid
burst_busy  out  1  sequencer is not in IDLE
burst_done  out  1  one-cycle pulse when a burst completes
addr_err  out  1  sticky flag: an out-of-range access occurred

Behaviour:
- Reset: data_out=0, data_valid=0, burst_busy=0, burst_done=0, addr_err=0. FSM goes to IDLE and the output FIFO is emptied. Memory contents are not cleared.
- Write: when wr_en=1 and wr_addr<DEPTH, each lane i with wr_lane_mask[i]=1 is written. Writes are accepted in every FSM state. When wr_addr>=DEPTH the write is dropped and addr_err is set.
- Lane mapping: word = rd_addr / R, lane = rd_addr % R. Lane 0 is bits [RD_WIDTH-1:0].
- Memory is read-first: a read of a word written in the same cycle returns the old data.
- Output path: a 2-entry FIFO drives data_out and data_valid.
  - data_valid is high exactly when the FIFO is non-empty.
  - A beat transfers on data_valid && out_ready.
  - data_out is held stable while data_valid=1 and out_ready=0.
- Random read (IDLE only):
  - rd_en is accepted when the FIFO has a free slot.
  - Data appears on data_out the cycle after acceptance (1-cycle latency) when the FIFO was empty.
  - If rd_addr >= DEPTH*R, the FIFO receives 0 and addr_err is set.
  - rd_en is ignored outside IDLE.
- FSM states:
  - IDLE: burst_start=1 with burst_len>0 -> RUN; load addr=burst_base, remaining=burst_len. burst_start=1 with burst_len=0 -> DONE. burst_start takes priority over a simultaneous rd_en; that rd_en is dropped.
  - RUN: issue one memory read per cycle while (FIFO occupancy + reads in flight) < 2. Each issue increments addr and decrements remaining. The address wraps from DEPTH*R-1 to 0; a burst that wraps does not set addr_err. Out-of-range burst_base sets addr_err and the affected beats return 0. When remaining reaches 0 -> DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight -> DONE.
  - DONE: burst_done=1 for exactly one cycle -> IDLE.
- burst_busy=1 in RUN, DRAIN and DONE.
- Exactly burst_len beats are delivered, in address order, with no loss or duplication under any out_ready pattern.
- Full throughput: one beat per cycle when out_ready is held high.
- rst asserted mid-burst aborts the burst. The next cycle is IDLE with no valid data, and no burst_done pulse is produced.
- addr_err clears only on rst.

Test Plan:
- Write word 5 = 0x44444444_33333333_22222222_11111111 with mask 4'hF; rd_addr=20..23 -> data_out 0x11111111, 0x22222222, 0x33333333, 0x44444444, each 1 cycle after rd_en.
- Rewrite word 5 with data 0xFFFFFFFF in all lanes, mask 4'b0100; read lanes 20..23 -> 0x11111111, 0x22222222, 0xFFFFFFFF, 0x44444444.
- Burst base=20, len=8, out_ready=1 -> 8 consecutive valid beats starting 2 cycles after burst_start, then burst_done pulses once and burst_busy drops.
- Same burst with out_ready toggling 1,0,0,1,... -> data stable while stalled, exactly 8 beats in order, FIFO never overflows.
- Burst base=DEPTH*4-2, len=4 -> lanes DEPTH*4-2, DEPTH*4-1, 0, 1 are delivered and addr_err stays 0. Then rd_addr=DEPTH*4 -> data_out 0 and addr_err=1 (sticky).
- Burst len=0 -> burst_done pulse with no data_valid. Separately, assert rst after the 3rd beat of a len=8 burst -> all outputs return to 0, no burst_done, and the next random read works.
